// File: rtl/tri_bounds_classify_pkg.sv
// tri_bounds_classify_pkg: shared types, outcode layout and reset clip bounds
package tri_bounds_classify_pkg;
  typedef enum logic [1:0] {CLS_ACCEPT = 2'd0, CLS_CLIP = 2'd1, CLS_REJECT = 2'd2} tri_class_e;
  localparam int AXES = 3;
  localparam int AX_X = 0;
  localparam int AX_Y = 1;
  localparam int AX_Z = 2;
  localparam int OC_W = 6;
  localparam int OC_XMIN = 0;
  localparam int OC_XMAX = 1;
  localparam int OC_YMIN = 2;
  localparam int OC_YMAX = 3;
  localparam int OC_ZMIN = 4;
  localparam int OC_ZMAX = 5;
  localparam int XMIN_DEF = -1000;
  localparam int XMAX_DEF = 1000;
  localparam int YMIN_DEF = -1000;
  localparam int YMAX_DEF = 1000;
  localparam int ZMIN_DEF = -1000;
  localparam int ZMAX_DEF = 1000;
  function automatic int bound_def(input int i);
    return i == OC_XMIN ? XMIN_DEF : i == OC_XMAX ? XMAX_DEF :
           i == OC_YMIN ? YMIN_DEF : i == OC_YMAX ? YMAX_DEF :
           i == OC_ZMIN ? ZMIN_DEF : ZMAX_DEF;
  endfunction
  function automatic tri_class_e classify(input logic [OC_W-1:0] any_oc, input logic [OC_W-1:0] all_oc);
    return all_oc != '0 ? CLS_REJECT : any_oc != '0 ? CLS_CLIP : CLS_ACCEPT;
  endfunction
endpackage

// File: rtl/tri_bounds_classify_vertex_outcode.sv
// vertex_outcode: strict signed compare of one vertex against six clip bounds
module vertex_outcode
  import tri_bounds_classify_pkg::*;
#(
  parameter int COORD_W = 16
) (
  input  logic [AXES*COORD_W-1:0]   vtx,
  input  logic [OC_W*COORD_W-1:0]   bounds,
  output logic [OC_W-1:0]           oc
);
  logic signed [COORD_W-1:0] p [AXES];
  logic signed [COORD_W-1:0] b [OC_W];
  for (genvar a = 0; a < AXES; a++) begin : g_p
    assign p[a] = vtx[a*COORD_W +: COORD_W];
  end
  for (genvar i = 0; i < OC_W; i++) begin : g_b
    assign b[i] = bounds[i*COORD_W +: COORD_W];
  end
  assign oc[OC_XMIN] = p[AX_X] < b[OC_XMIN];
  assign oc[OC_XMAX] = p[AX_X] > b[OC_XMAX];
  assign oc[OC_YMIN] = p[AX_Y] < b[OC_YMIN];
  assign oc[OC_YMAX] = p[AX_Y] > b[OC_YMAX];
  assign oc[OC_ZMIN] = p[AX_Z] < b[OC_ZMIN];
  assign oc[OC_ZMAX] = p[AX_Z] > b[OC_ZMAX];
endmodule

// File: rtl/tri_bounds_classify.sv
// tri_bounds_classify: two-stage streaming triangle outcode/classify with culling and stats
module tri_bounds_classify
  import tri_bounds_classify_pkg::*;
#(
  parameter int COORD_W   = 16,
  parameter int NUM_VERTS = 3,
  parameter int CNT_W     = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [NUM_VERTS*AXES*COORD_W-1:0] in_tri,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [NUM_VERTS*AXES*COORD_W-1:0] out_tri,
  output logic [1:0]                        out_class,
  output logic [NUM_VERTS*OC_W-1:0]         out_outcodes,
  input  logic                              cull_en,
  input  logic                              cfg_we,
  input  logic [2:0]                        cfg_sel,
  input  logic [COORD_W-1:0]                cfg_data,
  input  logic                              stat_clr,
  output logic [CNT_W-1:0]                  cnt_accept,
  output logic [CNT_W-1:0]                  cnt_clip,
  output logic [CNT_W-1:0]                  cnt_reject
);
  localparam int TW = NUM_VERTS*AXES*COORD_W;
  localparam int OW = NUM_VERTS*OC_W;
  logic [OC_W*COORD_W-1:0] bounds;
  logic [OW-1:0]           in_oc, s1_oc;
  logic [TW-1:0]           s1_tri;
  logic                    s1_v, s2_v, s2_cull, s2_adv, retire;
  logic [OC_W-1:0]         any_oc, all_oc;
  tri_class_e              s1_cls, s2_cls;
  for (genvar v = 0; v < NUM_VERTS; v++) begin : g_vtx
    vertex_outcode #(.COORD_W(COORD_W)) u_oc (
      .vtx   (in_tri[v*AXES*COORD_W +: AXES*COORD_W]),
      .bounds(bounds),
      .oc    (in_oc[v*OC_W +: OC_W])
    );
  end
  // new bounds apply to triangles captured after the write edge
  always_ff @(posedge clk)
    for (int i = 0; i < OC_W; i++)
      if (rst) bounds[i*COORD_W +: COORD_W] <= COORD_W'(bound_def(i));
      else if (cfg_we && cfg_sel == 3'(i)) bounds[i*COORD_W +: COORD_W] <= cfg_data;
  always_comb begin
    any_oc = '0;
    all_oc = '1;
    for (int v = 0; v < NUM_VERTS; v++) begin
      any_oc |= s1_oc[v*OC_W +: OC_W];
      all_oc &= s1_oc[v*OC_W +: OC_W];
    end
    s1_cls = classify(any_oc, all_oc);
  end
  assign s2_adv    = !s2_v || out_ready || s2_cull;
  assign in_ready  = !s1_v || s2_adv;
  assign out_valid = s2_v && !s2_cull;
  assign out_class = s2_cls;
  assign retire    = s2_v && (out_ready || s2_cull);
  always_ff @(posedge clk)
    if (rst) begin
      s1_v         <= 1'b0;
      s1_tri       <= '0;
      s1_oc        <= '0;
      s2_v         <= 1'b0;
      s2_cull      <= 1'b0;
      s2_cls       <= CLS_ACCEPT;
      out_tri      <= '0;
      out_outcodes <= '0;
    end else begin
      if (in_ready) s1_v <= in_valid;
      if (in_ready && in_valid) begin
        s1_tri <= in_tri;
        s1_oc  <= in_oc;
      end
      if (s2_adv) begin
        s2_v    <= s1_v;
        s2_cull <= s1_v && cull_en && s1_cls == CLS_REJECT;
      end
      if (s2_adv && s1_v) begin
        s2_cls       <= s1_cls;
        out_tri      <= s1_tri;
        out_outcodes <= s1_oc;
      end
    end
  // clear beats a coincident retire; counts stick at all-ones
  always_ff @(posedge clk)
    if (rst || stat_clr) begin
      cnt_accept <= '0;
      cnt_clip   <= '0;
      cnt_reject <= '0;
    end else begin
      cnt_accept <= cnt_accept + CNT_W'(retire && s2_cls == CLS_ACCEPT && cnt_accept != '1);
      cnt_clip   <= cnt_clip   + CNT_W'(retire && s2_cls == CLS_CLIP   && cnt_clip   != '1);
      cnt_reject <= cnt_reject + CNT_W'(retire && s2_cls == CLS_REJECT && cnt_reject != '1);
    end
endmodule

// File: tb/tb_tri_bounds_classify.sv
// tb_tri_bounds_classify: directed vector and scoreboard bench for tri_bounds_classify
module tb_tri_bounds_classify;
  import tri_bounds_classify_pkg::*;
  localparam int CW = 16;
  localparam int NV = 3;
  localparam int CNT_W = 4;
  localparam int TW = NV*3*CW;
  localparam int OW = NV*6;
  logic clk = 1'b0, rst = 1'b1;
  logic in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1;
  logic [TW-1:0] in_tri = '0, out_tri;
  logic [1:0] out_class;
  logic [OW-1:0] out_outcodes;
  logic cull_en = 1'b0, cfg_we = 1'b0, stat_clr = 1'b0;
  logic [2:0] cfg_sel = '0;
  logic [CW-1:0] cfg_data = '0;
  logic [CNT_W-1:0] cnt_accept, cnt_clip, cnt_reject;
  tri_bounds_classify #(.COORD_W(CW), .NUM_VERTS(NV), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_tri(in_tri),
    .out_valid(out_valid), .out_ready(out_ready), .out_tri(out_tri), .out_class(out_class),
    .out_outcodes(out_outcodes), .cull_en(cull_en), .cfg_we(cfg_we), .cfg_sel(cfg_sel),
    .cfg_data(cfg_data), .stat_clr(stat_clr), .cnt_accept(cnt_accept), .cnt_clip(cnt_clip),
    .cnt_reject(cnt_reject)
  );
  always #5 clk = ~clk;
  typedef struct packed {
    logic [TW-1:0] t;
    logic [1:0]    cls;
    logic [OW-1:0] oc;
  } exp_t;
  exp_t q[$];
  exp_t e;
  exp_t tbl [8];
  int checks = 0, errors = 0, n_out = 0;
  logic stall_p = 1'b0;
  logic [TW-1:0] tri_p;
  logic [1:0] cls_p;
  function automatic logic [TW-1:0] mk(input int x0, y0, z0, x1, y1, z1, x2, y2, z2);
    return {16'(z2), 16'(y2), 16'(x2), 16'(z1), 16'(y1), 16'(x1), 16'(z0), 16'(y0), 16'(x0)};
  endfunction
  task automatic chk_t(input string name, input logic [TW-1:0] act, input logic [TW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic chk_i(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  always @(negedge clk)
    if (rst) stall_p = 1'b0;
    else begin
      if (stall_p) begin
        chk_i("hold_valid", int'(out_valid), 1);
        chk_t("hold_tri", out_tri, tri_p);
        chk_i("hold_class", int'(out_class), int'(cls_p));
      end
      if (out_valid && out_ready) begin
        n_out++;
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got tri %0h expected none", out_tri);
        end else begin
          e = q.pop_front();
          chk_t("out_tri", out_tri, e.t);
          chk_i("out_class", int'(out_class), int'(e.cls));
          chk_i("out_outcodes", int'(out_outcodes), int'(e.oc));
        end
      end
      stall_p = out_valid && !out_ready;
      tri_p = out_tri;
      cls_p = out_class;
    end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic push(input logic [TW-1:0] t, input tri_class_e c, input logic [OW-1:0] oc);
    q.push_back('{t, c, oc});
  endtask
  task automatic send(input logic [TW-1:0] t, output int stalls);
    stalls = 0;
    in_valid = 1'b1;
    in_tri = t;
    @(negedge clk);
    while (!in_ready && stalls < 50) begin
      stalls++;
      @(negedge clk);
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready 0 expected 1");
    end
    tick();
    in_valid = 1'b0;
  endtask
  task automatic drain();
    int n = 0;
    repeat (3) tick();
    while ((q.size() != 0 || out_valid) && n < 100) begin
      n++;
      tick();
    end
    chk_i("drain_pending", q.size(), 0);
  endtask
  task automatic clr();
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
  endtask
  task automatic cfg(input int sel, input int data);
    cfg_we = 1'b1;
    cfg_sel = 3'(sel);
    cfg_data = 16'(data);
    tick();
    cfg_we = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    logic [TW-1:0] ta, tr, tb, tc, tp [5];
    int st, tot, n0;
    ta = mk(0, 0, 0, 10, 10, 10, -5, 3, 7);
    tr = mk(1500, 0, 0, 1500, 0, 0, 1500, 0, 0);
    tc = mk(1500, 0, 0, 0, 0, 0, 1, 1, 1);
    tbl[0] = '{ta, CLS_ACCEPT, '0};
    tbl[1] = '{tr, CLS_REJECT, 18'b000010_000010_000010};
    tbl[2] = '{tc, CLS_CLIP, 18'b000000_000000_000010};
    tbl[3] = '{mk(1000, -1000, 1000, 0, 0, 0, -1000, 1000, -1000), CLS_ACCEPT, '0};
    tbl[4] = '{mk(-1000, 0, 0, 0, -1001, 0, 0, 0, 0), CLS_CLIP, 18'b000000_000100_000000};
    tbl[5] = '{mk(0, 0, -2000, 2000, 0, -2000, -5, 5, -2000), CLS_REJECT, 18'b010000_010010_010000};
    tbl[6] = '{mk(2000, 0, 0, -2000, 0, 0, 0, 2000, 0), CLS_CLIP, 18'b001000_000001_000010};
    tbl[7] = '{mk(0, 0, 1001, 5, 5, 1001, -5, -5, 1001), CLS_REJECT, 18'b100000_100000_100000};
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_i("rst_in_ready", int'(in_ready), 1);
    chk_i("rst_out_valid", int'(out_valid), 0);
    chk_t("rst_out_tri", out_tri, '0);
    chk_i("rst_out_class", int'(out_class), 0);
    chk_i("rst_out_oc", int'(out_outcodes), 0);
    chk_i("rst_cnts", int'({cnt_accept, cnt_clip, cnt_reject}), 0);
    tick();
    push(ta, CLS_ACCEPT, '0);
    send(ta, st);
    @(negedge clk);
    chk_i("lat_s1_valid", int'(out_valid), 0);
    @(negedge clk);
    chk_i("lat_s2_valid", int'(out_valid), 1);
    drain();
    chk_i("lat_cnt_accept", int'(cnt_accept), 1);
    clr();
    tot = 0;
    for (int i = 0; i < 8; i++) begin
      q.push_back(tbl[i]);
      send(tbl[i].t, st);
      tot += st;
    end
    drain();
    chk_i("tbl_stalls", tot, 0);
    chk_i("tbl_cnt_accept", int'(cnt_accept), 2);
    chk_i("tbl_cnt_clip", int'(cnt_clip), 3);
    chk_i("tbl_cnt_reject", int'(cnt_reject), 3);
    clr();
    cull_en = 1'b1;
    n0 = n_out;
    tot = 0;
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 1) push(ta, CLS_ACCEPT, '0);
      send(i % 2 == 1 ? ta : tr, st);
      tot += st;
    end
    drain();
    cull_en = 1'b0;
    chk_i("cull_stalls", tot, 0);
    chk_i("cull_outputs", n_out - n0, 2);
    chk_i("cull_cnt_accept", int'(cnt_accept), 2);
    chk_i("cull_cnt_reject", int'(cnt_reject), 2);
    clr();
    n0 = n_out;
    for (int i = 0; i < 5; i++) begin
      tp[i] = mk(i, i, i, 20 + i, 0, 0, 0, 30 + i, 0);
      push(tp[i], CLS_ACCEPT, '0);
    end
    out_ready = 1'b0;
    fork
      begin
        int bst, btot;
        btot = 0;
        for (int i = 0; i < 5; i++) begin
          send(tp[i], bst);
          btot += bst;
        end
        chk_i("bp_stalled", int'(btot != 0), 1);
      end
      begin
        repeat (6) @(negedge clk);
        chk_i("bp_in_ready", int'(in_ready), 0);
        chk_i("bp_out_valid", int'(out_valid), 1);
        chk_t("bp_head", out_tri, tp[0]);
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();
    chk_i("bp_outputs", n_out - n0, 5);
    chk_i("bp_cnt_accept", int'(cnt_accept), 5);
    clr();
    tb = mk(500, 3, 3, 500, 4, 4, 500, 5, 5);
    push(mk(500, 0, 0, 500, 1, 1, 500, 2, 2), CLS_ACCEPT, '0);
    push(tb, CLS_REJECT, 18'b000010_000010_000010);
    chk_i("cfg_in_ready", int'(in_ready), 1);
    in_valid = 1'b1;
    in_tri = mk(500, 0, 0, 500, 1, 1, 500, 2, 2);
    cfg_we = 1'b1;
    cfg_sel = 3'd1;
    cfg_data = 16'd100;
    tick();
    cfg_we = 1'b0;
    in_tri = tb;
    tick();
    in_valid = 1'b0;
    drain();
    cfg(6, 5000);
    cfg(7, -5000);
    push(mk(50, 50, 50, 60, 60, 60, 70, 70, 70), CLS_ACCEPT, '0);
    send(mk(50, 50, 50, 60, 60, 60, 70, 70, 70), st);
    drain();
    chk_i("cfg_cnt_accept", int'(cnt_accept), 2);
    chk_i("cfg_cnt_reject", int'(cnt_reject), 1);
    cfg(1, 1000);
    clr();
    for (int i = 0; i < 15; i++) begin
      push(tc, CLS_CLIP, 18'b000000_000000_000010);
      send(tc, st);
    end
    drain();
    chk_i("sat_cnt_clip_full", int'(cnt_clip), 15);
    push(tc, CLS_CLIP, 18'b000000_000000_000010);
    send(tc, st);
    drain();
    chk_i("sat_cnt_clip_hold", int'(cnt_clip), 15);
    chk_i("sat_cnt_accept", int'(cnt_accept), 0);
    push(tc, CLS_CLIP, 18'b000000_000000_000010);
    send(tc, st);
    tick();
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    chk_i("clr_retired", q.size(), 0);
    chk_i("clr_cnt_clip", int'(cnt_clip), 0);
    drain();
    push(ta, CLS_ACCEPT, '0);
    send(ta, st);
    drain();
    chk_i("pre_rst_cnt_accept", int'(cnt_accept), 1);
    n0 = n_out;
    out_ready = 1'b0;
    send(ta, st);
    send(tc, st);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk_i("mid_rst_out_valid", int'(out_valid), 0);
    chk_i("mid_rst_in_ready", int'(in_ready), 1);
    chk_t("mid_rst_out_tri", out_tri, '0);
    chk_i("mid_rst_cnt_accept", int'(cnt_accept), 0);
    out_ready = 1'b1;
    repeat (5) tick();
    chk_i("mid_rst_outputs", n_out - n0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
